dmem_bus_ctrl: RTL
==================

# dmem_bus_ctrl

Data-memory bus controller for the MEM stage. It sits between the load/store byte-lane logic and a req/addr_ok/data_ok data-SRAM bus. It takes the already-formatted write data and byte strobes, runs one bus transaction per memory instruction, and stalls the pipeline until the transaction completes. It then returns the raw 32-bit read word to the byte-lane logic and holds it there until the pipeline advances.

## Interface
Parameters:
- ADDR_W, 32, address width of pipeline and bus.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  the MEM-stage instruction is a load or store.
- req_wstrb  in  4  byte write enables; 4'b0000 means load.
- req_addr  in  ADDR_W  effective address.
- req_wdata  in  32  lane-replicated store data.
- pipe_advance  in  1  MEM stage moves to WB at this edge; high only when no stall source is active.
- stall  out  1  holds the pipeline; combinational.
- rdata  out  32  registered raw read word, valid in DONE.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_wstrb  out  4  write byte strobes.
- data_addr  out  ADDR_W  word-aligned address.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  write done or read data valid.
- data_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE
  - When req_valid=1, latch req_wstrb, {req_addr[ADDR_W-1:2],2'b00} and req_wdata into the request registers, then go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - data_req=1. data_wr=|wstrb_latched. The bus fields come from the latched registers and stay constant.
  - data_addr_ok=1 and data_data_ok=0: go to WAIT.
  - data_addr_ok=1 and data_data_ok=1 in the same cycle: capture data_rdata into rdata for loads, then go to DONE.
  - data_addr_ok=0: stay in REQ. data_req and all fields keep their values.
- WAIT
  - data_req=0.
  - data_data_ok=1: capture data_rdata into rdata for loads, then go to DONE.
  - A data_data_ok seen in REQ without data_addr_ok is ignored.
- DONE
  - data_req=0, stall=0. rdata is held.
  - pipe_advance=1: go to IDLE.
  - pipe_advance=0: stay in DONE. This covers stalls from other sources.
  - req_valid is ignored in DONE, because the same instruction is still in MEM.
- Stores leave rdata unchanged.
- stall = (IDLE & req_valid) | REQ | WAIT.
- There is no cancel. A transaction that has been issued always runs to data_data_ok.
- Only one transaction is outstanding at a time.
- Reset values:
  - state IDLE.
  - data_req, data_wr 0.
  - data_wstrb 4'b0.
  - data_addr, data_wdata 0.
  - rdata 32'b0.
  - stall follows its equation, so it is 0 unless req_valid=1.
- Reset asserted in any state forces the reset values on the next edge. An in-flight bus response after reset is ignored while the controller is in IDLE.

## Timing
- Data_req is registered. It rises on the cycle after req_valid is first seen in IDLE.
- Minimum latency, with addr_ok and data_ok in the same cycle as the first data_req:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, handshake completes.
  - cycle 2: DONE, stall=0, rdata valid.
- Load/store occupancy is therefore 2 stall cycles minimum.
- Each cycle data_addr_ok is delayed adds 1 cycle. Each cycle data_data_ok is delayed after the accept cycle adds 1 cycle.
- Back-to-back memory instructions:
  - DONE with pipe_advance → IDLE.
  - The next instruction is seen in IDLE in the following cycle.
  - No request is issued in the DONE cycle itself.

## Test plan
- Load, zero-wait bus: req_valid=1, wstrb=0, addr=0x1000_0006, data_rdata=0xA1B2C3D4 with addr_ok and data_ok together in the REQ cycle.
  - Required: data_addr=0x1000_0004 and data_wr=0.
  - Required: stall high for exactly 2 cycles, then rdata=0xA1B2C3D4.
- Store with wait states: wstrb=4'b0100, wdata=0x5A5A5A5A, addr_ok delayed 2 cycles, data_ok 3 cycles after that.
  - Required: data_req held high for 3 cycles with constant fields.
  - Required: stall high for 7 cycles; rdata unchanged.
- Hold in DONE: load completes while pipe_advance=0 for 4 cycles.
  - Required: state stays DONE, stall=0, rdata stable.
  - Required: no new data_req, even though req_valid=1.
- Back-to-back: a store then a load, with pipe_advance pulsed in DONE.
  - Required: exactly two data_req episodes.
  - Required: the second episode begins 2 cycles after the first DONE.
- Reset mid-WAIT: assert rst while in WAIT, then deliver data_data_ok=1 with data_rdata=0xFFFFFFFF.
  - Required: IDLE and all outputs at reset values.
  - Required: rdata stays 0, because the late response is ignored.

Source files
------------

// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_ctrl_if
// Brief    : req/addr_ok/data_ok data-SRAM bus bundle between the MEM-stage
//            bus controller (master) and the data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_wstrb,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_wstrb,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bus_ctrl
// Brief    : MEM-stage data-memory bus controller. Issues one req/addr_ok/
//            data_ok transaction per load/store, stalls the pipeline until it
//            completes and holds the raw read word until the stage advances.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
    parameter int ADDR_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              req_valid,
    input  wire logic [3:0]        req_wstrb,
    input  wire logic [ADDR_W-1:0] req_addr,
    input  wire logic [31:0]       req_wdata,
    input  wire logic              pipe_advance,
    output logic                   stall,
    output logic [31:0]            rdata,
    dmem_bus_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_req;
    logic [3:0]        r_wstrb;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_latch;
    logic              w_capture;
    logic              w_is_load;

    // The byte offset inside the word only matters to the byte-lane logic.
    logic              w_addr_lsb_unused;
    assign w_addr_lsb_unused = ^req_addr[1:0];

    assign w_is_load = ~|r_wstrb;

    // Next-state decode, request latch and response capture conditions.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A data_ok without addr_ok here is stale and is ignored.
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.data_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // The same instruction is still in MEM, so req_valid is ignored.
                if (pipe_advance) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered bus request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == S_REQ);
        end
    end

    // Request fields are captured once and held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstrb <= 4'b0000;
            r_addr  <= '0;
            r_wdata <= 32'h0;
        end else if (w_latch) begin
            r_wstrb <= req_wstrb;
            r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= req_wdata;
        end
    end

    // Read word is captured for loads only; stores leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_capture && w_is_load) begin
            r_rdata <= bus.data_rdata;
        end
    end

    // Stall covers the IDLE cycle that sees the request through to the response.
    always_comb begin
        stall = ((r_state == S_IDLE) && req_valid) ||
                (r_state == S_REQ) ||
                (r_state == S_WAIT);
    end

    assign rdata          = r_rdata;
    assign bus.data_req   = r_req;
    assign bus.data_wr    = ~w_is_load;
    assign bus.data_wstrb = r_wstrb;
    assign bus.data_addr  = r_addr;
    assign bus.data_wdata = r_wdata;

endmodule
`default_nettype wire
